// File: rtl/myproject_mul_share_pkg.sv
// Shared widths and the pipeline stage record for the time-shared multiplier.
package myproject_mul_share_pkg;

    localparam int DIN0_WIDTH = 16;
    localparam int DIN1_WIDTH = 6;
    localparam int DOUT_WIDTH = DIN0_WIDTH + DIN1_WIDTH;
    // Requester ID width; must equal $clog2(NUM_REQ) of the instantiated scheduler.
    localparam int ID_W       = 2;

    typedef struct packed {
        logic                         vld;
        logic [ID_W-1:0]              id;
        logic signed [DOUT_WIDTH-1:0] p;
    } stage_t;

endpackage

// File: rtl/myproject_mul_share_sched_if.sv
// Requester operand bus plus the tagged response channel of the shared multiplier.
interface myproject_mul_share_sched_if
    import myproject_mul_share_pkg::*;
#(
    parameter int NUM_REQ = 4
);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DIN0_WIDTH-1:0] req_din0;
    logic [NUM_REQ*DIN1_WIDTH-1:0] req_din1;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [ID_W-1:0]               rsp_id;
    logic [DOUT_WIDTH-1:0]         rsp_dout;

    modport master (
        output req_valid, req_din0, req_din1, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_dout
    );

    modport slave (
        input  req_valid, req_din0, req_din1, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_dout
    );

endinterface

// File: rtl/myproject_rr_arb.sv
// Stateless round-robin arbiter: scans from ptr_i+1 and grants the first active request.
module myproject_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    idx_o
);

    logic [ID_W-1:0] cand;
    logic            found;

    // NOTE: every variable assigned here gets a default first so no latch is inferred.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        cand    = '0;
        found   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(ptr_i) + k) % NUM_REQ);
            if (en_i && !found && req_i[cand]) begin
                grant_o[cand] = 1'b1;
                idx_o         = cand;
                found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/myproject_mul_share_sched.sv
// Shares one 16s x 6s multiplier among NUM_REQ requesters through a full-stall pipeline.
module myproject_mul_share_sched
    import myproject_mul_share_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int MUL_STAGES = 2
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst,
    myproject_mul_share_sched_if.slave    bus,
    output logic                          busy
);

    localparam int LAST = MUL_STAGES - 1;

    stage_t                  st_q [MUL_STAGES];
    stage_t                  st_d [MUL_STAGES];
    logic [ID_W-1:0]         ptr_q, ptr_d;
    logic [ID_W-1:0]         grant_idx;
    logic [NUM_REQ-1:0]      grant;
    logic                    advance;
    logic                    accept;
    logic signed [DIN0_WIDTH-1:0] op_a;
    logic signed [DIN1_WIDTH-1:0] op_b;

    assign advance = !st_q[LAST].vld || bus.rsp_ready;

    myproject_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_i   (bus.req_valid),
        .ptr_i   (ptr_q),
        .en_i    (advance),
        .grant_o (grant),
        .idx_o   (grant_idx)
    );

    // The grant is already gated by req_valid and advance, so any grant bit is an accept.
    assign bus.req_ready = grant;
    assign accept        = |grant;

    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                op_a = bus.req_din0[i*DIN0_WIDTH +: DIN0_WIDTH];
                op_b = bus.req_din1[i*DIN1_WIDTH +: DIN1_WIDTH];
            end
        end
    end

    // Bubbles shift valid only, so id/product keep their last value on the response port.
    always_comb begin
        st_d  = st_q;
        ptr_d = ptr_q;
        if (advance) begin
            st_d[0].vld = accept;
            if (accept) begin
                st_d[0].id = grant_idx;
                st_d[0].p  = DOUT_WIDTH'(op_a) * DOUT_WIDTH'(op_b);
                ptr_d      = grant_idx;
            end
            for (int s = 1; s < MUL_STAGES; s++) begin
                st_d[s].vld = st_q[s-1].vld;
                if (st_q[s-1].vld) begin
                    st_d[s].id = st_q[s-1].id;
                    st_d[s].p  = st_q[s-1].p;
                end
            end
        end
    end

    // NOTE: data fields are reset too, since rsp_id/rsp_dout must read zero straight out of reset.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            ptr_q <= ID_W'(NUM_REQ - 1);
            for (int s = 0; s < MUL_STAGES; s++) begin
                st_q[s] <= '0;
            end
        end else begin
            // NOTE: state registers take non-blocking assignments so all stages shift on the same edge.
            ptr_q <= ptr_d;
            st_q  <= st_d;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int s = 0; s < MUL_STAGES; s++) begin
            busy = busy | st_q[s].vld;
        end
    end

    assign bus.rsp_valid = st_q[LAST].vld;
    assign bus.rsp_id    = st_q[LAST].id;
    assign bus.rsp_dout  = st_q[LAST].p;

endmodule

// File: doc/myproject_mul_share_sched.md
Name: myproject_mul_share_sched

Overview:
Time-shares one pipelined signed multiplier (16s x 6s -> 22s) among NUM_REQ requesters. A round-robin arbiter issues one operand pair per cycle into a fixed-latency multiply pipeline. Each result returns on a single response channel tagged with the requester ID. The block sits between layer compute loops and the shared DSP product resource, so several small dot-product lanes can use one multiplier.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DIN0_WIDTH, 16, signed operand A width
DIN1_WIDTH, 6, signed operand B width
DOUT_WIDTH, 22, signed product width; must equal DIN0_WIDTH+DIN1_WIDTH
MUL_STAGES, 2, issue-to-response latency in cycles (1..4)
ID_W, 2, requester ID width, = clog2(NUM_REQ)

Ports:
ap_clk  in  1  clock, rising edge
ap_rst  in  1  reset, asynchronous, active-high
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  per-requester accept
req_din0  in  NUM_REQ*DIN0_WIDTH  packed operand A; requester i at bits [i*DIN0_WIDTH +: DIN0_WIDTH]
req_din1  in  NUM_REQ*DIN1_WIDTH  packed operand B, same packing
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accept
rsp_id  out  ID_W  requester index of the result
rsp_dout  out  DOUT_WIDTH  signed product
busy  out  1  any pipeline stage occupied

Behaviour:
- One clock (ap_clk). ap_rst is asynchronous and active-high.
- Reset:
  - all pipeline valid bits = 0; rsp_valid = 0, rsp_id = 0, rsp_dout = 0, busy = 0.
  - RR pointer = NUM_REQ-1, so requester 0 has highest priority first.
  - In-flight operations are discarded and never reported.
- Pipeline and advance:
  - MUL_STAGES register stages, each holding {valid, id, data}.
  - Global advance = !last_valid || rsp_ready.
  - On !advance, every stage holds and no issue occurs.
  - Bubbles are not collapsed: full-stall pipeline.
- Arbitration (combinational):
  - Scan from ptr+1 modulo NUM_REQ; the first req_valid found gets grant.
  - req_ready[i] = grant[i] & advance; at most one bit set.
  - Accept = req_valid[i] & req_ready[i].
  - ptr updates to the granted index only on accept; otherwise it holds.
  - Requesters must not gate req_valid on req_ready. Once asserted, req_valid and the operands stay stable until accepted.
- Latency:
  - Accept in cycle k with no stall -> rsp_valid = 1 in cycle k+MUL_STAGES.
  - Each stall cycle adds exactly one cycle.
  - Throughput: 1 result/cycle while rsp_ready = 1.
- Arithmetic:
  - rsp_dout = $signed(din0) * $signed(din1), full precision. No overflow, no rounding, no saturation.
  - Product formed in stage 1; later stages only delay it.
- Response:
  - rsp_valid/rsp_id/rsp_dout are the last-stage registers.
  - While rsp_valid & !rsp_ready, they are held stable.
  - rsp_dout and rsp_id keep their last value when rsp_valid = 0.
- busy = OR of all stage valid bits.
- Boundary cases:
  - No req_valid: a bubble enters the pipeline and ptr holds.
  - Single active requester: it is granted every cycle (back-to-back).
  - Consume and issue in the same cycle: allowed (advance = 1 through rsp_ready).
  - ptr at NUM_REQ-1: wraps to 0.
  - Reset asserted mid-stream: outputs clear immediately (asynchronous), with no glitch to rsp_valid = 1.

Decomposition:
- Shared package myproject_mul_share_pkg holds:
  - the DIN0/DIN1/DOUT width constants;
  - stage struct typedef {logic vld; logic [ID_W-1:0] id; logic signed [DOUT_WIDTH-1:0] p}.
- One sub-module: myproject_rr_arb (NUM_REQ; inputs req, ptr, en; outputs one-hot grant and encoded index), with no internal state. ptr lives in the parent.
- The multiply stays inline in stage 1 so synthesis can map it to a DSP.

Test Plan:
- Req0 only, din0 = 32767, din1 = 31, rsp_ready = 1 -> rsp_valid 2 cycles after accept, rsp_id = 0, rsp_dout = 1015777 (22'h0F7FE1).
- Req2 only, din0 = -32768, din1 = -32 -> rsp_dout = 1048576 (22'h100000). Then din0 = -32768, din1 = 31 -> rsp_dout = -1015808.
- All 4 req_valid held high with distinct operands, rsp_ready = 1 -> issue order 0,1,2,3,0,1; one result per cycle; each rsp_id matches its product.
- Continuous traffic, rsp_ready = 0 for 3 cycles:
  - all req_ready = 0;
  - rsp_valid/rsp_id/rsp_dout stable;
  - no loss or duplication after release;
  - latency is extended by 3.
- Req1 and req3 valid, ptr after reset -> grants 1,3,1,3. Drop req3 mid-stream -> req1 granted every cycle.
- Assert ap_rst (asynchronous, between edges) while 2 ops are in flight:
  - rsp_valid = 0 and busy = 0 immediately;
  - after release the first grant goes to the lowest-index valid requester;
  - no stale results appear.
